// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 32 x 32-bit register file with two asynchronous read ports
//                and one synchronous write port. Register 0 reads as zero.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile #(
    parameter int BYPASS = 0
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeRegister,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_writeReg,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB
);

    localparam int c_NREGS = 32;

    logic [c_NREGS-1:0] w_wr_dec;
    logic [31:0]        w_rd_in [0:c_NREGS-1];
    logic [31:0]        w_mux_a;
    logic [31:0]        w_mux_b;

    // One-hot write decode gated by the write strobe.
    assign w_wr_dec   = {{(c_NREGS-1){1'b0}}, ctrl_writeEnable} << ctrl_writeRegister;
    assign w_rd_in[0] = 32'h0;

    generate
        for (genvar i = 1; i < c_NREGS; i++) begin : g_reg
            logic [31:0] r_q;

            always_ff @(posedge clock or negedge ctrl_reset_n) begin
                if (!ctrl_reset_n) begin
                    r_q <= 32'h0;
                end else if (w_wr_dec[i]) begin
                    r_q <= data_writeReg;
                end
            end

            assign w_rd_in[i] = r_q;
        end
    endgenerate

    assign w_mux_a = w_rd_in[ctrl_readRegA];
    assign w_mux_b = w_rd_in[ctrl_readRegB];

    generate
        if (BYPASS != 0) begin : g_bypass
            logic w_hit_a;
            logic w_hit_b;

            // Index 0 never bypasses so r0 stays hardwired to zero.
            assign w_hit_a = ctrl_writeEnable && (ctrl_writeRegister == ctrl_readRegA)
                             && (ctrl_readRegA != 5'd0);
            assign w_hit_b = ctrl_writeEnable && (ctrl_writeRegister == ctrl_readRegB)
                             && (ctrl_readRegB != 5'd0);

            assign data_readRegA = w_hit_a ? data_writeReg : w_mux_a;
            assign data_readRegB = w_hit_b ? data_writeReg : w_mux_b;
        end else begin : g_no_bypass
            assign data_readRegA = w_mux_a;
            assign data_readRegB = w_mux_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile
//  Description : Directed self-checking bench for regfile, with and without
//                write-to-read bypass.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeRegister;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;

    int n_checks = 0;
    int n_errors = 0;

    regfile #(.BYPASS(0)) u_dut0 (
        .clock              (clock),
        .ctrl_reset_n       (ctrl_reset_n),
        .ctrl_writeEnable   (ctrl_writeEnable),
        .ctrl_writeRegister (ctrl_writeRegister),
        .ctrl_readRegA      (ctrl_readRegA),
        .ctrl_readRegB      (ctrl_readRegB),
        .data_writeReg      (data_writeReg),
        .data_readRegA      (rd_a0),
        .data_readRegB      (rd_b0)
    );

    regfile #(.BYPASS(1)) u_dut1 (
        .clock              (clock),
        .ctrl_reset_n       (ctrl_reset_n),
        .ctrl_writeEnable   (ctrl_writeEnable),
        .ctrl_writeRegister (ctrl_writeRegister),
        .ctrl_readRegA      (ctrl_readRegA),
        .ctrl_readRegB      (ctrl_readRegB),
        .data_writeReg      (data_writeReg),
        .data_readRegA      (rd_a1),
        .data_readRegB      (rd_b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Write one register across a single rising edge, strobe dropped afterwards.
    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        @(negedge clock);
        ctrl_writeEnable   = 1'b1;
        ctrl_writeRegister = idx;
        data_writeReg      = d;
        @(negedge clock);
        ctrl_writeEnable   = 1'b0;
    endtask

    // Read one index on both ports of both instances; all must agree.
    task automatic rd_all(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        ctrl_readRegA = idx;
        ctrl_readRegB = idx;
        #1;
        check({tag, "_a0"}, rd_a0, exp);
        check({tag, "_b0"}, rd_b0, exp);
        check({tag, "_a1"}, rd_a1, exp);
        check({tag, "_b1"}, rd_b1, exp);
    endtask

    initial begin
        ctrl_reset_n       = 1'b0;
        ctrl_writeEnable   = 1'b0;
        ctrl_writeRegister = 5'd0;
        ctrl_readRegA      = 5'd0;
        ctrl_readRegB      = 5'd0;
        data_writeReg      = 32'h0;

        // Reset held, including across an edge carrying a write: write must be lost.
        ctrl_writeEnable   = 1'b1;
        ctrl_writeRegister = 5'd3;
        data_writeReg      = 32'h1234_5678;
        repeat (2) @(posedge clock);
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        ctrl_reset_n     = 1'b1;
        for (int i = 0; i < 32; i++) rd_all("reset_sweep", 5'(i), 32'h0);

        // Fill r1..r31 with distinct patterns.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 | 32'(i));
        for (int i = 0; i < 32; i++)
            rd_all("fill", 5'(i), (i == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(i)));

        // Different indices on A and B at once.
        ctrl_readRegA = 5'd9;
        ctrl_readRegB = 5'd22;
        #1;
        check("indep_a", rd_a0, 32'hA5A5_0009);
        check("indep_b", rd_b0, 32'hA5A5_0016);

        // r0 ignores writes, even combinationally on the bypass instance.
        @(negedge clock);
        ctrl_writeEnable   = 1'b1;
        ctrl_writeRegister = 5'd0;
        data_writeReg      = 32'hFFFF_FFFF;
        ctrl_readRegA      = 5'd0;
        ctrl_readRegB      = 5'd0;
        #1;
        check("r0_byp_a", rd_a1, 32'h0);
        check("r0_byp_b", rd_b1, 32'h0);
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        rd_all("r0_after", 5'd0, 32'h0);
        for (int i = 1; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            #1;
            check("r0_others", rd_a0, 32'hA5A5_0000 | 32'(i));
        end

        // Read-during-write on r5.
        wr(5'd5, 32'h1111_1111);
        ctrl_writeEnable   = 1'b1;
        ctrl_writeRegister = 5'd5;
        data_writeReg      = 32'h2222_2222;
        ctrl_readRegA      = 5'd5;
        ctrl_readRegB      = 5'd6;
        #1;
        check("rdw_old", rd_a0, 32'h1111_1111);
        check("rdw_byp", rd_a1, 32'h2222_2222);
        check("rdw_byp_other", rd_b1, 32'hA5A5_0006);
        @(posedge clock);
        #1;
        check("rdw_new0", rd_a0, 32'h2222_2222);
        check("rdw_new1", rd_a1, 32'h2222_2222);
        @(negedge clock);
        ctrl_writeEnable = 1'b0;

        // Disabled write leaves everything untouched.
        ctrl_writeRegister = 5'd7;
        data_writeReg      = 32'hDEAD_BEEF;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int i = 1; i < 32; i++)
            rd_all("we_low", 5'(i), (i == 5) ? 32'h2222_2222 : (32'hA5A5_0000 | 32'(i)));

        // Asynchronous reset between edges.
        wr(5'd31, 32'hCAFE_F00D);
        ctrl_readRegA = 5'd31;
        ctrl_readRegB = 5'd9;
        #1;
        check("r31_loaded", rd_a0, 32'hCAFE_F00D);
        @(posedge clock);
        #3;
        ctrl_reset_n = 1'b0;
        #1;
        check("async_rst_a0", rd_a0, 32'h0);
        check("async_rst_a1", rd_a1, 32'h0);
        check("async_rst_b0", rd_b0, 32'h0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        for (int i = 0; i < 32; i++) rd_all("post_rst", 5'(i), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
